seg7_scroll_driver: RTL and testbench
=====================================

// Module: seg7_scroll_driver
// PURPOSE
//  Downstream of the 4-bit delay counter: consumes its 0..14 count as a scroll offset.
//  Shows a 4-character window of a 16-character message on a 4-digit common-anode
//  7-segment display. Time-multiplexes the anodes with a dead-time (blank) phase
//  before each digit to suppress ghosting.
//  Latches the offset only at frame boundaries, so a frame never mixes two offsets.
// PARAMETERS
//  TICK_W    16                   scan tick every 2**TICK_W clk cycles (sim: 2)
//  ON_TICKS  3                    ticks each anode stays lit per visit (>=1)
//  MSG       64'h0123456789ABCDEF 16 nibble chars; char i = MSG[63-4i -: 4]
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high
//  offset       in   4  scroll position from the delay counter; 0..15 accepted
//  enable       in   1  1 = scan; 0 = display dark
//  an           out  4  anode drive, active-low; an[3] = leftmost digit
//  seg          out  7  {g,f,e,d,c,b,a}, active-low
//  frame_done   out  1  one-cycle pulse after digit 0 finishes its ON phase
// BEHAVIOUR
//  Reset values: an=4'b1111, seg=7'b1111111, frame_done=0.
//    Internal: tick cnt=0, state=S_DEAD, d=3, off_q=0.
//  Tick: TICK_W-bit free-running counter; tick=1 for one cycle when cnt is all ones.
//    Counter wraps to 0.
//  Digit d (3..0) shows char index (off_q + (3-d)) mod 16. Use a 4-bit add; wrap is
//    intended.
//  FSM states:
//  - S_OFF:  an=1111, seg=blank.
//            Leave when enable=1: go to S_DEAD with d=3; off_q<=offset.
//  - S_DEAD: an=1111, seg holds the char for digit d.
//            On tick: an[d]<=0, go to S_ON, ON counter=0.
//  - S_ON:   an[d]=0. On tick: ON counter++.
//            At ON_TICKS ticks: an<=1111, d<=d-1, seg<=char of the new d, go to S_DEAD.
//            If d was 0: d<=3, off_q<=offset, and frame_done=1 in that same cycle.
//  Any state with enable=0: next cycle goes to S_OFF, an=1111, seg=blank.
//    An ON phase cut short gives no frame_done.
//  Invariants:
//  - At most one an bit is low at any time.
//  - seg never changes while any an bit is low.
//  Timing:
//  - Digit period = (ON_TICKS+1) ticks.
//  - Frame = 4*(ON_TICKS+1)*2**TICK_W cycles. Sim defaults: 4*4*4 = 64 cycles.
//  - Changing offset mid-frame has no visible effect until the next frame.
//    This covers upstream wrap 14 -> 0.
//  Mid-operation reset: all outputs return to reset values asynchronously; off_q=0.
//  All outputs are registered. Latency from offset to visible: <= 1 frame + 1 cycle.
// CONFIGURATION
//  SEG7_BLINK_EN defined:
//  - Extra input blink (1 bit). While blink=1, frames with odd frame parity are
//    forced dark: an=1111 for the whole frame. Frame timing and frame_done are
//    unchanged. Frame-parity bit resets to 0, i.e. first frame lit.
//  SEG7_BLINK_EN undefined:
//  - No blink port. Every frame is lit.
// STRUCTURE
//  Shared include seg7_defs.vh holds:
//  - state encodings S_OFF/S_DEAD/S_ON
//  - SEG_BLANK = 7'b1111111
//  - the 16 hex glyph constants: 0=1000000, 1=1111001, 8=0000000, A=0001000,
//    F=0001110, ...
//  Sub-module hex_to_seg7: purely combinational 4-bit code -> 7-bit active-low
//    glyph. Instantiate once, fed by the char-index mux.
// TESTING
//  Sim params: TICK_W=2, ON_TICKS=3.
//  1. Reset, enable=1, offset=0.
//     -> an sequence 0111,1111,1011,1111,1101,1111,1110,1111.
//     -> seg while lit = glyph 0,1,2,3 (1000000,1111001,0100100,0110000).
//     -> frame_done every 64 cycles.
//  2. offset=13.
//     -> digits 3..0 show D,E,F,0 (wrap-around).
//     -> seg never changes while an!=1111 (assertion).
//  3. Change offset 0->5 mid-frame.
//     -> current frame completes with 0,1,2,3.
//     -> next frame shows 5,6,7,8.
//  4. enable low during S_ON of digit 1.
//     -> an=1111 and seg=blank next cycle, no frame_done.
//     -> re-enable restarts at digit 3.
//  5. Assert reset during S_ON of digit 2.
//     -> an=1111, seg=1111111, frame_done=0 immediately (async).
//  6. SEG7_BLINK_EN, blink=1.
//     -> frames alternate lit/dark.
//     -> frame_done is still pulsed every 64 cycles.

Source files
------------

// File: rtl/seg7_scroll_driver_pkg.sv
// Shared definitions for the scrolling 7-segment driver: FSM states, blank code and hex glyphs.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_scroll_driver_pkg;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_DEAD = 2'd1,
    S_ON   = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Character idx of a 16-nibble message; character 0 sits in the top nibble.
  function automatic logic [3:0] char_at(input logic [63:0] msg, input logic [3:0] idx);
    logic [63:0] sh;
    sh = msg >> {4'd15 - idx, 2'b00};
    return sh[3:0];
  endfunction

endpackage

// File: rtl/seg7_scroll_driver_hex_to_seg7.sv
// Combinational 4-bit hex code to active-low 7-segment glyph.
module hex_to_seg7
  import seg7_scroll_driver_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      default: seg_o = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg7_scroll_driver.sv
// Scans a 4-character window of a 16-character message onto a common-anode display,
// with a blank dead-time before each digit. Optional frame blinking under SEG7_BLINK_EN.
module seg7_scroll_driver
  import seg7_scroll_driver_pkg::*;
#(
  parameter int          TICK_W   = 16,
  parameter int          ON_TICKS = 3,
  parameter logic [63:0] MSG      = 64'h0123456789ABCDEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] offset,
  input  logic       enable,
`ifdef SEG7_BLINK_EN
  input  logic       blink,
`endif
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output state_e     dbg_state
);

  localparam int ON_W = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;
  localparam logic [ON_W-1:0] ON_LAST = ON_W'(ON_TICKS - 1);

  logic [TICK_W-1:0] cnt_q;
  state_e            state_q;
  logic [1:0]        d_q;
  logic [3:0]        off_q;
  logic [ON_W-1:0]   on_cnt_q;
  logic [3:0]        an_q;
  logic [6:0]        seg_q;
  logic              fd_q;

  logic       tick;
  logic       on_done;
  logic       lit_en;
  logic [3:0] disp_off;
  logic [1:0] disp_d;
  logic [3:0] char_idx;
  logic [3:0] char_code;
  logic [6:0] glyph;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_q + 1'b1;
  end

  assign tick    = &cnt_q;
  assign on_done = tick && (on_cnt_q == ON_LAST);

`ifdef SEG7_BLINK_EN
  logic parity_q;

  // Parity flips once per completed frame, so the first frame after reset is lit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_q ^ fd_q;
  end

  assign lit_en = !(blink && parity_q);
`else
  assign lit_en = 1'b1;
`endif

  // The glyph is looked up for the digit about to be shown, so seg is loaded while dark.
  always_comb begin
    disp_off = off_q;
    disp_d   = d_q;
    if (state_q == S_OFF) begin
      disp_off = offset;
      disp_d   = 2'd3;
    end else if (state_q == S_ON && on_done) begin
      if (d_q == 2'd0) begin
        disp_off = offset;
        disp_d   = 2'd3;
      end else begin
        disp_d = d_q - 2'd1;
      end
    end
    char_idx = disp_off + {2'b00, 2'd3 - disp_d};
  end

  assign char_code = char_at(MSG, char_idx);

  hex_to_seg7 u_glyph (
    .code_i (char_code),
    .seg_o  (glyph)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_DEAD;
      d_q      <= 2'd3;
      off_q    <= 4'd0;
      on_cnt_q <= '0;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
      fd_q     <= 1'b0;
    end else begin
      fd_q <= 1'b0;
      if (!enable) begin
        state_q <= S_OFF;
        an_q    <= 4'b1111;
        seg_q   <= SEG_BLANK;
      end else begin
        case (state_q)
          S_OFF: begin
            state_q <= S_DEAD;
            d_q     <= 2'd3;
            off_q   <= offset;
            seg_q   <= glyph;
          end
          S_DEAD: begin
            seg_q <= glyph;
            if (tick) begin
              an_q     <= lit_en ? ~(4'b0001 << d_q) : 4'b1111;
              on_cnt_q <= '0;
              state_q  <= S_ON;
            end
          end
          S_ON: begin
            if (tick) begin
              if (on_cnt_q == ON_LAST) begin
                an_q    <= 4'b1111;
                seg_q   <= glyph;
                state_q <= S_DEAD;
                d_q     <= d_q - 2'd1;
                if (d_q == 2'd0) begin
                  off_q <= offset;
                  fd_q  <= 1'b1;
                end
              end else begin
                on_cnt_q <= on_cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= S_OFF;
            an_q    <= 4'b1111;
            seg_q   <= SEG_BLANK;
          end
        endcase
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scroll_driver.sv
// Bench for seg7_scroll_driver: random offsets per frame, expected lit digits queued ahead,
// monitor pops one entry each time a digit lights. Build with SEG7_BLINK_EN for the blink run.
module tb_seg7_scroll_driver;

  localparam logic [63:0] MSG = 64'h0123456789ABCDEF;
  localparam logic [6:0]  BLANK = 7'b1111111;

  logic       clk;
  logic       reset;
  logic [3:0] offset;
  logic       enable;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_done;
  logic [1:0] dbg_state;
`ifdef SEG7_BLINK_EN
  logic       blink;
`endif

  int checks;
  int failures;
  logic [10:0] exp_q[$];
  logic [3:0]  seg_offs[8];
  bit          blink_model;

  seg7_scroll_driver #(
    .TICK_W   (2),
    .ON_TICKS (3),
    .MSG      (MSG)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .offset     (offset),
    .enable     (enable),
`ifdef SEG7_BLINK_EN
    .blink      (blink),
`endif
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model
  function automatic logic [6:0] ref_glyph(input logic [3:0] c);
    logic [6:0] t[16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[c];
  endfunction

  function automatic logic [3:0] ref_char(input int i);
    logic [63:0] m;
    m = MSG;
    return m[63 - 4*i -: 4];
  endfunction

  // Queue the digits of one frame that are expected to light, left to right.
  task automatic push_frame(input logic [3:0] off, input int ndig, input int fidx);
    logic [3:0] an_exp;
    if (blink_model && (fidx % 2 == 1)) return;
    for (int k = 0; k < ndig; k++) begin
      an_exp = 4'b1111;
      an_exp[3-k] = 1'b0;
      exp_q.push_back({an_exp, ref_glyph(ref_char((int'(off) + k) % 16))});
    end
  endtask

  // driver tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_fd(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_arrives", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_an(input logic [3:0] pat, input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (an == pat) seen = 1'b1;
    end
    check("anode_reached", {31'd0, seen}, 32'd1);
  endtask

  // After reset the first frame always uses offset 0; otherwise seg_offs[0] is latched on enable.
  task automatic run_segment(input int n, input bit from_reset);
    int r;
    if (from_reset) begin
      push_frame(4'd0, 4, 0);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      @(negedge clk);
      offset = seg_offs[0];
      enable = 1'b1;
      push_frame(seg_offs[0], 4, 0);
    end
    for (int f = 1; f < n; f++) begin
      r = $urandom_range(1, 40);
      repeat (r) @(negedge clk);
      offset = seg_offs[f];
      push_frame(seg_offs[f], 4, f);
      wait_fd(80);
    end
    wait_fd(80);
    enable = 1'b0;
  endtask

  // scoreboard monitor
  initial begin
    logic [3:0]  prev_an;
    logic [6:0]  prev_seg;
    logic [10:0] e;
    int          cyc;
    int          fd_last;
    bit          fd_valid;
    prev_an  = 4'b1111;
    prev_seg = BLANK;
    cyc      = 0;
    fd_last  = 0;
    fd_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_an  = 4'b1111;
        fd_valid = 1'b0;
      end else begin
        cyc++;
        if ($countones(~an) > 1) begin
          checks++;
          failures++;
          $display("FAIL one_hot_anode got an=%b want at most one low bit", an);
        end
        if (an != 4'b1111 && prev_an != 4'b1111) begin
          checks++;
          if (seg !== prev_seg) begin
            failures++;
            $display("FAIL seg_stable_while_lit got seg=%b want seg=%b", seg, prev_seg);
          end
        end
        if (an != 4'b1111 && prev_an == 4'b1111) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_lit got an=%b seg=%b want dark", an, seg);
          end else begin
            e = exp_q.pop_front();
            if ({an, seg} !== e) begin
              failures++;
              $display("FAIL lit_digit got an=%b seg=%b want an=%b seg=%b", an, seg, e[10:7], e[6:0]);
            end
          end
        end
        if (frame_done) begin
          if (fd_valid) begin
            checks++;
            if (cyc - fd_last != 64) begin
              failures++;
              $display("FAIL frame_period got=%0d want=64", cyc - fd_last);
            end
          end
          fd_last  = cyc;
          fd_valid = 1'b1;
        end
        if (!enable) fd_valid = 1'b0;
        prev_an  = an;
        prev_seg = seg;
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] o;
    bit saw_fd;
    bit bad_dark;
    checks      = 0;
    failures    = 0;
    blink_model = 1'b0;
    reset       = 1'b0;
    enable      = 1'b1;
    offset      = 4'($urandom_range(1, 15));
`ifdef SEG7_BLINK_EN
    blink = 1'b0;
`endif
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg", {25'd0, seg}, {25'd0, BLANK});
    check("reset_frame_done", {31'd0, frame_done}, 32'd0);

    // reset start (offset 0), wrap at 13, then 0 -> 5 mid-frame
    seg_offs[0] = 4'd0;
    seg_offs[1] = 4'd13;
    seg_offs[2] = 4'd0;
    seg_offs[3] = 4'd5;
    run_segment(4, 1'b1);

    // random offsets, including the top of the range
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 3; i++) seg_offs[i] = 4'($urandom_range(0, 15));
      if (s == 0) seg_offs[1] = 4'd15;
      if (s == 1) seg_offs[2] = 4'd14;
      run_segment(3, 1'b0);
    end

    // enable dropped while digit 1 is lit
    @(negedge clk);
    o = 4'($urandom_range(0, 15));
    offset = o;
    enable = 1'b1;
    push_frame(o, 3, 0);
    wait_an(4'b1101, 200);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disable_an", {28'd0, an}, 32'hF);
    check("disable_seg", {25'd0, seg}, {25'd0, BLANK});
    check("disable_frame_done", {31'd0, frame_done}, 32'd0);
    saw_fd   = 1'b0;
    bad_dark = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (frame_done) saw_fd = 1'b1;
      if (an != 4'b1111 || seg != BLANK) bad_dark = 1'b1;
    end
    check("off_no_frame_done", {31'd0, saw_fd}, 32'd0);
    check("off_stays_dark", {31'd0, bad_dark}, 32'd0);
    seg_offs[0] = 4'($urandom_range(0, 15));
    seg_offs[1] = 4'($urandom_range(0, 15));
    run_segment(2, 1'b0);

    // asynchronous reset while digit 2 is lit
    @(negedge clk);
    o = 4'($urandom_range(0, 15));
    offset = o;
    enable = 1'b1;
    push_frame(o, 2, 0);
    wait_an(4'b1011, 200);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_an", {28'd0, an}, 32'hF);
    check("async_reset_seg", {25'd0, seg}, {25'd0, BLANK});
    check("async_reset_frame_done", {31'd0, frame_done}, 32'd0);
    offset = 4'($urandom_range(1, 15));
    repeat (2) @(negedge clk);
    seg_offs[1] = 4'($urandom_range(0, 15));
    run_segment(2, 1'b1);

`ifdef SEG7_BLINK_EN
    // blinking: odd frames since reset stay dark
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    blink  = 1'b1;
    blink_model = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 1; i < 4; i++) seg_offs[i] = 4'($urandom_range(0, 15));
    run_segment(4, 1'b1);
    blink = 1'b0;
    blink_model = 1'b0;
`endif

    repeat (10) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
